w_normalize: RTL and testbench

W_NORMALIZE -- requirements
Module: w_normalize

---
 rtl/fp_double.sv | 115 +++++++++++
 rtl/double_sqrt.sv | 48 ++++
 rtl/w_normalize.sv | 145 ++++++++++++++
 tb/tb_w_normalize.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_double.sv
// IEEE-754 binary64 helpers shared by the normalisation datapath.
// All rounding is round-to-nearest-even. Subnormal operands are read as zero,
// and results that would be subnormal are flushed to a signed zero.
// Inf/NaN get minimal propagation only; none arise from finite, non-overflowing inputs.
package fp_double;

  typedef logic [63:0] double_t;

  localparam double_t FpZero = 64'h0000_0000_0000_0000;
  localparam double_t FpOne  = 64'h3FF0_0000_0000_0000;
  localparam double_t FpQNaN = 64'h7FF8_0000_0000_0000;

  // m is the 53-bit significand with its leading one at bit 52. g is the first
  // dropped bit. st is the OR of every bit below g.
  function automatic double_t fp_round(logic s, logic signed [13:0] e, logic [52:0] m,
                                       logic g, logic st);
    logic [53:0]        mr;
    logic signed [13:0] er;
    mr = {1'b0, m} + {53'd0, g & (st | m[0])};
    er = e;
    if (mr[53]) begin
      mr = mr >> 1;
      er = er + 14'sd1;
    end
    if (er >= 14'sd2047) return {s, 11'h7FF, 52'd0};
    if (er <= 14'sd0) return {s, 63'd0};
    return {s, er[10:0], mr[51:0]};
  endfunction

  function automatic double_t fp_mul(double_t a, double_t b);
    logic               s;
    logic [105:0]       p;
    logic signed [13:0] e;
    s = a[63] ^ b[63];
    if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) return {s, 11'h7FF, 52'd0};
    if (a[62:52] == 11'd0 || b[62:52] == 11'd0) return {s, 63'd0};
    p = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
    e = $signed({3'b0, a[62:52]}) + $signed({3'b0, b[62:52]}) - 14'sd1023;
    if (p[105]) return fp_round(s, e + 14'sd1, p[105:53], p[52], |p[51:0]);
    return fp_round(s, e, p[104:52], p[51], |p[50:0]);
  endfunction

  function automatic double_t fp_add(double_t a, double_t b);
    double_t            x, y;
    logic [55:0]        mx, my;
    logic [56:0]        sum;
    logic [10:0]        d;
    logic signed [13:0] e;
    if (a[62:52] == 11'h7FF) return a;
    if (b[62:52] == 11'h7FF) return b;
    // Exact zero sum of two zeros is -0 only when both are -0.
    if (b[62:52] == 11'd0) return (a[62:52] == 11'd0) ? {a[63] & b[63], 63'd0} : a;
    if (a[62:52] == 11'd0) return b;
    if (a[62:0] >= b[62:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[62:52] - y[62:52];
    mx = {1'b1, x[51:0], 3'b000};
    my = {1'b1, y[51:0], 3'b000};
    // Three extra bits (guard, round, sticky); shifted-out bits fold into the sticky LSB.
    if (d > 11'd55) my = 56'd1;
    else my = (my >> d) | {55'd0, |(my & ~({56{1'b1}} << d))};
    e = $signed({3'b0, x[62:52]});
    if (x[63] == y[63]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[56]) begin
        sum = {1'b0, sum[56:1]} | {56'd0, sum[0]};
        e   = e + 14'sd1;
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, my};
      if (sum == 57'd0) return FpZero;
      for (int i = 0; i < 55; i++) begin
        if (!sum[55]) begin
          sum = sum << 1;
          e   = e - 14'sd1;
        end
      end
    end
    return fp_round(x[63], e, sum[55:3], sum[2], |sum[1:0]);
  endfunction

  function automatic double_t fp_div(double_t a, double_t b);
    logic               s;
    logic [107:0]       n, dv;
    logic [55:0]        q;
    logic [52:0]        r;
    logic signed [13:0] e;
    s = a[63] ^ b[63];
    if (b[62:52] == 11'd0) return (a[62:52] == 11'd0) ? FpQNaN : {s, 11'h7FF, 52'd0};
    if (a[62:52] == 11'd0) return {s, 63'd0};
    n  = {1'b1, a[51:0], 55'd0};
    dv = {55'd0, 1'b1, b[51:0]};
    // Quotient of two significands lies in (0.5, 2), so q has 55 or 56 bits.
    q  = 56'(n / dv);
    r  = 53'(n % dv);
    e  = $signed({3'b0, a[62:52]}) - $signed({3'b0, b[62:52]}) + 14'sd1023;
    if (q[55]) return fp_round(s, e, q[55:3], q[2], (|q[1:0]) | (|r));
    return fp_round(s, e - 14'sd1, q[54:2], q[1], q[0] | (|r));
  endfunction

  function automatic double_t fp_abs(double_t a);
    return {1'b0, a[62:0]};
  endfunction

  function automatic logic fp_lt(double_t a, double_t b);
    if (a[63] != b[63]) return a[63] && ((a[62:0] | b[62:0]) != 63'd0);
    return a[63] ? (a[62:0] > b[62:0]) : (a[62:0] < b[62:0]);
  endfunction

endpackage

// File: rtl/double_sqrt.sv
// Combinational binary64 square root, round-to-nearest-even.
//   radicand : operand (binary64)
//   root     : sqrt(radicand); -x gives NaN, +/-0 and +inf pass through
module double_sqrt
  import fp_double::*;
(
  input  double_t radicand,
  output double_t root
);

  logic signed [13:0] e;
  logic [53:0]        m;
  logic [109:0]       x;
  logic [57:0]        rem, trial;
  logic [54:0]        r;

  always_comb begin
    e = $signed({3'b0, radicand[62:52]}) - 14'sd1023;
    // Make the exponent even so it halves exactly; the significand absorbs the odd bit.
    if (e[0]) begin
      m = {1'b1, radicand[51:0], 1'b0};
      e = e - 14'sd1;
    end else begin
      m = {1'b0, 1'b1, radicand[51:0]};
    end
    // Integer sqrt of m * 2^56 yields 55 result bits: 53 significand, guard, round.
    x   = {m, 56'd0};
    rem = '0;
    r   = '0;
    trial = '0;
    for (int i = 54; i >= 0; i--) begin
      rem   = {rem[55:0], x[2*i+1 -: 2]};
      trial = {1'b0, r, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        r   = {r[53:0], 1'b1};
      end else begin
        r = {r[53:0], 1'b0};
      end
    end

    root = fp_round(1'b0, (e >>> 1) + 14'sd1023, r[54:2], r[1], r[0] | (rem != 58'd0));
    if (radicand[62:52] == 11'd0) root = radicand;
    else if (radicand[63]) root = FpQNaN;
    else if (radicand[62:52] == 11'h7FF) root = radicand;
  end

endmodule

// File: rtl/w_normalize.sv
// Normalises an update vector w' to unit length and tests convergence against
// the previous weight vector: w_new = w'/||w'||, converged = |1 - |w_new.w_old|| < EPS.
//   clk, rst (sync, active-high)
//   start          : sample inputs and begin; honoured in IDLE only
//   vector_w_prime : unnormalised update, SIZE_N binary64 elements
//   vector_w_old   : previous weight vector
//   vector_w_new   : last result, held until the next completion
//   converged      : convergence flag for the last result
//   zero_norm      : last w' had zero norm (w_new then copies w_old)
//   busy           : operation in progress (ACCUM..DONE)
//   valid          : one-cycle pulse when results update
module w_normalize
  import fp_double::*;
#(
  parameter int unsigned SIZE_N = 8,
  parameter real         EPS    = 1.0e-6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  double_t [SIZE_N-1:0] vector_w_prime,
  input  double_t [SIZE_N-1:0] vector_w_old,
  output double_t [SIZE_N-1:0] vector_w_new,
  output logic                 converged,
  output logic                 zero_norm,
  output logic                 busy,
  output logic                 valid
);

  localparam int unsigned IdxW    = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
  localparam double_t     EpsBits = $realtobits(EPS);

  typedef enum logic [2:0] {StIdle, StAccum, StSqrt, StDivide, StDot, StDone} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q;
  double_t              acc_q, norm_q;
  double_t [SIZE_N-1:0] wp_q, wo_q, wn_q, w_new_q;
  logic                 converged_q, zero_norm_q;

  double_t mac_a, mac_b, mac_out, sqrt_out, conv_diff;
  logic    last, acc_zero, dot_conv;

  assign last     = idx_q == IdxW'(SIZE_N - 1);
  assign acc_zero = acc_q[62:52] == 11'd0;

  // One multiply-add serves both the sum of squares and the dot product;
  // acc_q holds whichever sum is in progress.
  always_comb begin
    mac_a = wp_q[idx_q];
    mac_b = wp_q[idx_q];
    if (state_q == StDot) begin
      mac_a = wn_q[idx_q];
      mac_b = wo_q[idx_q];
    end
  end

  assign mac_out   = fp_add(acc_q, fp_mul(mac_a, mac_b));
  assign conv_diff = fp_add(FpOne, {1'b1, mac_out[62:0]});
  assign dot_conv  = fp_lt(fp_abs(conv_diff), EpsBits);

  double_sqrt u_sqrt (
    .radicand(acc_q),
    .root    (sqrt_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StAccum;
      StAccum:  if (last) state_d = StSqrt;
      StSqrt:   state_d = acc_zero ? StDone : StDivide;
      StDivide: if (last) state_d = StDot;
      StDot:    if (last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      acc_q       <= FpZero;
      norm_q      <= FpZero;
      wn_q        <= '0;
      w_new_q     <= '0;
      converged_q <= 1'b0;
      zero_norm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            acc_q <= FpZero;
            idx_q <= '0;
          end
        end
        StAccum: begin
          acc_q <= mac_out;
          idx_q <= last ? '0 : idx_q + IdxW'(1);
        end
        StSqrt: begin
          norm_q <= sqrt_out;
          if (acc_zero) begin
            w_new_q     <= wo_q;
            zero_norm_q <= 1'b1;
            converged_q <= 1'b0;
          end
        end
        StDivide: begin
          wn_q[idx_q] <= fp_div(wp_q[idx_q], norm_q);
          idx_q       <= last ? '0 : idx_q + IdxW'(1);
          if (last) acc_q <= FpZero;
        end
        StDot: begin
          acc_q <= mac_out;
          idx_q <= last ? '0 : idx_q + IdxW'(1);
          // Publish on the way into DONE so results are valid alongside the pulse.
          if (last) begin
            w_new_q     <= wn_q;
            converged_q <= dot_conv;
            zero_norm_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Input hold copies; contents are don't-care until the next accepted start.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && start) begin
      wp_q <= vector_w_prime;
      wo_q <= vector_w_old;
    end
  end

  assign vector_w_new = w_new_q;
  assign converged    = converged_q;
  assign zero_norm    = zero_norm_q;
  assign busy         = state_q != StIdle;
  assign valid        = state_q == StDone;

endmodule

// File: tb/tb_w_normalize.sv
// Bench for w_normalize: table of directed vectors plus hand-written sequences for
// start-while-busy, mid-run reset, held start and reset/start priority.
module tb_w_normalize;
  import fp_double::*;

  localparam int N = 8;

  logic               clk = 1'b0;
  logic               rst, start;
  double_t [N-1:0]    vector_w_prime, vector_w_old, vector_w_new;
  logic               converged, zero_norm, busy, valid;
  int                 checks = 0;
  int                 errors = 0;

  always #5 clk = ~clk;

  w_normalize #(.SIZE_N(N), .EPS(1.0e-6)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .vector_w_prime(vector_w_prime),
    .vector_w_old  (vector_w_old),
    .vector_w_new  (vector_w_new),
    .converged     (converged),
    .zero_norm     (zero_norm),
    .busy          (busy),
    .valid         (valid)
  );

  typedef struct {
    string           name;
    double_t [N-1:0] wp, wo, wn;
    logic            conv, zero;
    int              lat;
  } vec_t;

  vec_t vecs[6];

  function automatic double_t d(real r);
    return $realtobits(r);
  endfunction

  task automatic check(input string name, input logic [N*64-1:0] act,
                       input logic [N*64-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 presents start; cycle c is observed #1 after the c-th following edge.
  task automatic run_vec(input vec_t v);
    int              lat, pulses;
    double_t [N-1:0] cap_wn;
    logic            cap_conv, cap_zero;
    lat = -1;
    pulses = 0;
    cap_wn = '0;
    cap_conv = 1'b0;
    cap_zero = 1'b0;
    vector_w_prime = v.wp;
    vector_w_old   = v.wo;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      start = 1'b0;
      if (c == 1) check({v.name, " busy after start"}, busy, 1'b1);
      if (c == 2) begin
        vector_w_prime = {N{d(7.0)}};
        vector_w_old   = {N{d(-3.0)}};
      end
      if (valid) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          cap_wn = vector_w_new;
          cap_conv = converged;
          cap_zero = zero_norm;
        end
      end
      if (c == v.lat + 1) check({v.name, " busy after done"}, busy, 1'b0);
    end
    check({v.name, " latency"}, lat, v.lat);
    check({v.name, " valid pulses"}, pulses, 1);
    check({v.name, " w_new"}, cap_wn, v.wn);
    check({v.name, " converged"}, cap_conv, v.conv);
    check({v.name, " zero_norm"}, cap_zero, v.zero);
    check({v.name, " w_new held"}, vector_w_new, v.wn);
    check({v.name, " converged held"}, converged, v.conv);
  endtask

  initial begin
    int v1, v2, pulses;

    for (int i = 0; i < 6; i++) begin
      vecs[i].wp = '0;
      vecs[i].wo = '0;
      vecs[i].wn = '0;
      vecs[i].conv = 1'b0;
      vecs[i].zero = 1'b0;
      vecs[i].lat = 26;
    end
    vecs[0].name = "unit";
    vecs[0].wp[0] = d(3.0);  vecs[0].wp[1] = d(4.0);
    vecs[0].wo[0] = d(0.6);  vecs[0].wo[1] = d(0.8);
    vecs[0].wn[0] = d(0.6);  vecs[0].wn[1] = d(0.8);
    vecs[0].conv = 1'b1;
    vecs[1].name = "signflip";
    vecs[1].wp[7] = d(-2.0); vecs[1].wo[7] = d(1.0); vecs[1].wn[7] = d(-1.0);
    vecs[1].conv = 1'b1;
    vecs[2].name = "orthogonal";
    vecs[2].wp[0] = d(1.0);  vecs[2].wo[1] = d(1.0); vecs[2].wn[0] = d(1.0);
    vecs[3].name = "zero";
    vecs[3].wp[2] = 64'h8000_0000_0000_0000;
    vecs[3].wo[0] = d(0.5);  vecs[3].wo[1] = d(-1.5);
    vecs[3].wo[2] = d(2.0);  vecs[3].wo[7] = d(0.25);
    vecs[3].wn = vecs[3].wo;
    vecs[3].zero = 1'b1;
    vecs[3].lat = 10;
    vecs[4].name = "uniform";
    for (int i = 0; i < 4; i++) begin
      vecs[4].wp[i] = d(1.0);
      vecs[4].wo[i] = d(0.5);
      vecs[4].wn[i] = d(0.5);
    end
    vecs[4].conv = 1'b1;
    vecs[5].name = "thirds";
    vecs[5].wp[0] = d(2.0);  vecs[5].wp[1] = d(-2.0); vecs[5].wp[2] = d(1.0);
    vecs[5].wo[7] = d(1.0);
    vecs[5].wn[0] = d(2.0 / 3.0);
    vecs[5].wn[1] = d(-2.0 / 3.0);
    vecs[5].wn[2] = d(1.0 / 3.0);

    rst = 1'b1;
    start = 1'b0;
    vector_w_prime = '0;
    vector_w_old = '0;
    step();
    step();
    rst = 1'b0;
    check("reset busy", busy, 1'b0);
    check("reset valid", valid, 1'b0);
    check("reset converged", converged, 1'b0);
    check("reset zero_norm", zero_norm, 1'b0);
    check("reset w_new", vector_w_new, '0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start pulses in ACCUM (cycle 3) and DIVIDE (cycle 12) with different data.
    vector_w_prime = vecs[0].wp;
    vector_w_old = vecs[0].wo;
    start = 1'b1;
    v1 = -1;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      start = (c == 3 || c == 12);
      if (c == 3) begin
        vector_w_prime = vecs[2].wp;
        vector_w_old = vecs[2].wo;
      end
      if (valid) begin
        pulses++;
        if (v1 < 0) begin
          v1 = c;
          check("ignored start w_new", vector_w_new, vecs[0].wn);
          check("ignored start converged", converged, 1'b1);
        end
      end
    end
    check("ignored start latency", v1, 26);
    check("ignored start pulses", pulses, 1);

    // Mid-run reset at cycle 12 discards the result.
    vector_w_prime = vecs[5].wp;
    vector_w_old = vecs[5].wo;
    start = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = 1'b0;
      if (valid) pulses++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst valid", valid, 1'b0);
    check("midrst w_new", vector_w_new, '0);
    check("midrst converged", converged, 1'b0);
    check("midrst zero_norm", zero_norm, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step();
      if (valid) pulses++;
    end
    check("midrst no valid", pulses, 0);
    run_vec(vecs[0]);

    // Start held high: retriggers from IDLE in the cycle after DONE.
    vector_w_prime = vecs[4].wp;
    vector_w_old = vecs[4].wo;
    start = 1'b1;
    v1 = -1;
    v2 = -1;
    pulses = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 30) start = 1'b0;
      if (c == 27) check("held start idle gap", busy, 1'b0);
      if (c == 28) check("held start rebusy", busy, 1'b1);
      if (valid) begin
        pulses++;
        if (v1 < 0) v1 = c;
        else if (v2 < 0) v2 = c;
      end
    end
    check("held start first valid", v1, 26);
    check("held start second valid", v2, 53);
    check("held start pulses", pulses, 2);

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    check("rst priority busy", busy, 1'b0);
    step();
    check("rst priority still idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
